mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit with private HI/LO registers.
- Sits beside the ALU in the execute stage. Consumes the two GPR read operands (rs/rt) and the decoded mult/div/mthi/mtlo request from control.
- Produces HI/LO for mfhi/mflo write-back.
- Asserts busy for a fixed latency so the controller can stall the next mult/div/mf*/mt* instruction.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (must be >= 1).
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (must be >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
- a  input  32  operand A (rs read data).
- b  input  32  operand B (rt read data).
- op  input  3  operation: 0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
- start  input  1  request strobe; sampled on the rising edge.
- busy  output  1  1 while a mult/div is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (rst=0, asynchronous): hi=0, lo=0, busy=0, cycle counter=0, pending result cleared, state=IDLE. Takes effect without a clock edge.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Acceptance: start=1 and busy=0 at a rising edge T0.
- start while busy=1: ignored entirely, for any op. Operands are not captured, HI/LO are not touched, and the in-flight op is unaffected.
- op 4/5 (mthi/mtlo) accepted in IDLE: hi<=a (or lo<=a) at edge T0. busy stays 0, state stays IDLE. The other register is unchanged.
- op 6/7: no effect, stays IDLE.
- op 0-3 accepted:
  - At T0, latch a, b and op; load counter with N (MULT_CYCLES for op 0/1, DIV_CYCLES for op 2/3); go to RUN. busy=1 after edge T0.
  - Each edge in RUN decrements the counter.
  - At edge T0+N: hi/lo take the result, busy returns to 0, state returns to IDLE.
  - Net: busy is high for exactly N clock periods.
  - hi/lo keep their old values throughout RUN; there is no partial-result visibility.
- Back-to-back: start at edge T0+N (the busy-drop edge) is not accepted, because busy=1 was sampled. The earliest next acceptance is edge T0+N+1.
- Arithmetic, on the latched operands:
  - multu: {hi,lo} = zero-extended 64-bit product a*b.
  - mult: {hi,lo} = signed 64-bit two's-complement product.
  - divu: lo = a/b, hi = a%b, unsigned.
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (div or divu): lo=32'hFFFFFFFF, hi=a. Still takes DIV_CYCLES.
  - div overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- Implementation freedom: the result may be computed iteratively or at capture and held. Externally only the latency and final values are observable.
- Operand changes on a/b during RUN must not affect the result.
- Reset asserted mid-RUN aborts the op. hi/lo become 0 (not the pending result) and busy=0 immediately.
- No combinational path from a/b/op/start to any output; all outputs are registered.

Test Plan:
- Reset: drive rst=0 mid-RUN of a div -> hi=0, lo=0, busy=0 without waiting for a clock edge. After release, the pending result never appears.
- multu and mult latency:
  - multu a=32'hFFFFFFFF, b=2 -> busy high exactly 5 cycles; then hi=1, lo=32'hFFFFFFFE.
  - mult with the same operands -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
  - hi/lo unchanged during busy.
- Signed divide:
  - div a=-7 (32'hFFFFFFF9), b=2 -> after 10 cycles lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - divu a=7, b=2 -> lo=3, hi=1.
- Divide corner cases:
  - divu a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, after 10 cycles.
  - div a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Ignored starts: during a mult, pulse start with op=4 (a=32'h1234) and op=3 -> neither has any effect; the final hi/lo are the mult result. Start on the busy-drop edge is also ignored.
- mthi/mtlo and back-to-back:
  - From IDLE, mthi a=32'hAAAA0000 then mtlo a=32'h5555 on consecutive edges -> hi=32'hAAAA0000, lo=32'h5555, busy never asserts.
  - Then multu accepted at T0+N+1 after a prior op -> correct result with 5-cycle latency.
  - Change a/b during RUN -> result reflects the latched operands.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO, result applied after a fixed latency.
// Latency MULT_CYCLES / DIV_CYCLES edges after acceptance; starts while busy are dropped.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [1:0]    op_q;

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic [63:0] res;

  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as q=0x80000000, r=0.
  always_comb begin
    ua = (op_q[0] && a_q[31]) ? -a_q : a_q;
    ub = (op_q[0] && b_q[31]) ? -b_q : b_q;
    uq = 32'hFFFF_FFFF;
    ur = ua;
    if (ub != 32'b0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (op_q[0] && (a_q[31] ^ b_q[31])) ? -uq : uq;
    r = (op_q[0] && a_q[31]) ? -ur : ur;
    res = {r, q};
    if (b_q == 32'b0) begin
      res = {a_q, 32'hFFFF_FFFF};
    end
    if (op_q[1] == 1'b0) begin
      res = op_q[0] ? prod_s : prod_u;
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= CW'(MULT_CYCLES);
                state <= RUN;
              end
              3'd2, 3'd3: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= CW'(DIV_CYCLES);
                state <= RUN;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= res[63:32];
            lo    <= res[31:0];
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: fixed vectors, hand-written corner sequences, and random ops against a reference model.
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic straight from the operation definitions.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] chi, input logic [31:0] clo);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: p = {32'b0, x} * {32'b0, y};
      3'd1: p = 64'(sx * sy);
      3'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd3: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          p = {sr[31:0], sq[31:0]};
        end
      end
      3'd4: p = {x, clo};
      3'd5: p = {chi, x};
      default: p = {chi, clo};
    endcase
    return p;
  endfunction

  function automatic int lat(input logic [2:0] o);
    return (o < 2) ? MULT_CYCLES : (o < 4) ? DIV_CYCLES : 0;
  endfunction

  // Called at a negedge; issues one op, scrambles operands during RUN, checks latency/hold/result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int cnt;
    int held_bad;
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
    cnt = 0;
    held_bad = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (hi !== mhi || lo !== mlo) held_bad++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(cnt), 32'(lat(o)));
    chk({name, "_hold"}, 32'(held_bad), 32'd0);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
    mhi = ehi;
    mlo = elo;
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int cnt, bad;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu_max"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg"});
    vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"});
    vecs.push_back('{3'd2, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2"});
    vecs.push_back('{3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by0"});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7_m2"});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, "mult_minmin"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0"});

    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    // mthi then mtlo on consecutive edges
    op = 3'd4; a = 32'hAAAA_0000; start = 1'b1;
    @(negedge clk);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hAAAA_0000);
    chk("mthi_lo_kept", lo, mlo);
    op = 3'd5; a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_hi", hi, 32'hAAAA_0000);
    chk("mtlo_lo", lo, 32'h0000_5555);
    mhi = 32'hAAAA_0000;
    mlo = 32'h0000_5555;

    // starts during a mult, including on the busy-drop edge, are ignored
    op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    bad = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (hi !== mhi || lo !== mlo) bad++;
      start = 1'b0;
      if (cnt == 2) begin op = 3'd4; a = 32'h1234; start = 1'b1; end
      if (cnt == 3) begin op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1; end
      if (cnt == MULT_CYCLES) begin op = 3'd5; a = 32'hDEAD; start = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_latency", 32'(cnt), 32'(MULT_CYCLES));
    chk("ign_hold", 32'(bad), 32'd0);
    chk("ign_busy_after", {31'b0, busy}, 32'd0);
    chk("ign_hi", hi, 32'd1);
    chk("ign_lo", lo, 32'hFFFF_FFFE);
    mhi = 32'd1;
    mlo = 32'hFFFF_FFFE;

    // back-to-back: accepted at the first edge after the drop
    run_op(3'd0, 32'd3, 32'd5, 32'd0, 32'd15, "b2b_multu");

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      e = model(ro, ra, rb, mhi, mlo);
      run_op(ro, ra, rb, e[63:32], e[31:0], $sformatf("rand%0d_op%0d", i, ro));
    end

    // async reset in the middle of a div
    run_op(3'd4, 32'h77, 32'd0, 32'h77, mlo, "pre_mthi");
    run_op(3'd5, 32'h88, 32'd0, 32'h77, 32'h88, "pre_mtlo");
    op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #1 rst = 1'b1;
    mhi = 32'd0;
    mlo = 32'd0;
    bad = 0;
    repeat (DIV_CYCLES + 5) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    chk("arst_no_late_result", 32'(bad), 32'd0);
    run_op(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, "post_rst_divu");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
